// File: rtl/accel_spi_controller.sv
// accel_spi_controller: SPI mode-0 master framing cmd + addr + data bytes for the accelerometer link.
// Optional ACCEL_SPI_AUTOPOLL_EN adds periodic burst reads of POLL_ADDR. Rev 1.0
`default_nettype none

module accel_spi_controller #(
  parameter int         CLK_DIV     = 4,
  parameter int         MAX_BURST   = 6,
  parameter logic [7:0] POLL_ADDR   = 8'h0E,
  parameter int         POLL_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Start,
  input  logic       i_Write,
  input  logic [7:0] i_Addr,
  input  logic [7:0] i_Wdata,
  input  logic [2:0] i_Len,
  output logic       o_Busy,
  output logic       o_Done,
  output logic [7:0] o_Rdata,
  output logic       o_Rvalid,
  output logic [2:0] o_Byte_Idx,
  output logic       o_Src,
  output logic       o_SPI_Clk,
  output logic       o_SPI_CSLow,
  output logic       o_SPI_Mosi,
  input  logic       i_SPI_Miso
);

  localparam int             DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]     MAX_LEN   = 4'(MAX_BURST);
  localparam logic [7:0]     CMD_WRITE = 8'h0A;
  localparam logic [7:0]     CMD_READ  = 8'h0B;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    CS_GAP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [2:0]       bit_cnt, bit_nxt;
  logic [3:0]       byte_cnt, byte_nxt;
  logic [3:0]       last_byte, last_nxt;
  logic             is_write, wr_nxt;
  logic [7:0]       addr_q, addr_nxt;
  logic [7:0]       wdata_q, wdata_nxt;
  logic [7:0]       tx, tx_nxt;
  logic [7:0]       rx, rx_nxt;
  logic             sclk, sclk_nxt;
  logic             cs_n, csn_nxt;
  logic             mosi, mosi_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  logic             rvalid, rvalid_nxt;
  logic [7:0]       rdata, rdata_nxt;
  logic [2:0]       byte_idx, idx_nxt;
  logic             src, src_nxt;

  logic             req, req_write, req_src;
  logic [7:0]       req_addr;
  logic [2:0]       req_len;
  logic [3:0]       req_n;
  logic             div_last;
  logic [7:0]       next_tx;
  logic [7:0]       rx_full;

`ifdef ACCEL_SPI_AUTOPOLL_EN
  localparam int PCNT_W = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;

  logic [PCNT_W-1:0] poll_cnt;
  logic              pending;
  logic              poll_wrap;

  assign poll_wrap = (poll_cnt == PCNT_W'(POLL_PERIOD - 1));

  // A wrap while already pending simply leaves the flag set; the user request wins a tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      poll_cnt <= poll_wrap ? '0 : poll_cnt + PCNT_W'(1);
      if (poll_wrap)
        pending <= 1'b1;
      else if (state == IDLE && pending && !i_Start)
        pending <= 1'b0;
    end
  end

  assign req       = i_Start | pending;
  assign req_write = i_Start & i_Write;
  assign req_addr  = i_Start ? i_Addr : POLL_ADDR;
  assign req_len   = i_Start ? i_Len : 3'(MAX_BURST);
  assign req_src   = ~i_Start;
`else
  logic unused_poll_cfg;
  assign unused_poll_cfg = ^POLL_ADDR ^ (POLL_PERIOD != 0);

  assign req       = i_Start;
  assign req_write = i_Write;
  assign req_addr  = i_Addr;
  assign req_len   = i_Len;
  assign req_src   = 1'b0;
`endif

  always_comb begin
    req_n = {1'b0, req_len};
    if (req_write || req_len == 3'd0)
      req_n = 4'd1;
    else if ({1'b0, req_len} > MAX_LEN)
      req_n = MAX_LEN;
  end

  assign div_last = (div_cnt == DIV_LAST);
  assign next_tx  = (byte_cnt == 4'd0) ? addr_q : (is_write ? wdata_q : 8'h00);
  assign rx_full  = {rx[6:0], i_SPI_Miso};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= 3'd7;
      byte_cnt  <= '0;
      last_byte <= '0;
      is_write  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx        <= '0;
      rx        <= '0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      byte_idx  <= '0;
      src       <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      byte_cnt  <= byte_nxt;
      last_byte <= last_nxt;
      is_write  <= wr_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      tx        <= tx_nxt;
      rx        <= rx_nxt;
      sclk      <= sclk_nxt;
      cs_n      <= csn_nxt;
      mosi      <= mosi_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      rvalid    <= rvalid_nxt;
      rdata     <= rdata_nxt;
      byte_idx  <= idx_nxt;
      src       <= src_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    byte_nxt   = byte_cnt;
    last_nxt   = last_byte;
    wr_nxt     = is_write;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    tx_nxt     = tx;
    rx_nxt     = rx;
    sclk_nxt   = sclk;
    csn_nxt    = cs_n;
    mosi_nxt   = mosi;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    rvalid_nxt = 1'b0;
    rdata_nxt  = rdata;
    idx_nxt    = byte_idx;
    src_nxt    = src;

    case (state)
      IDLE: begin
        div_nxt  = '0;
        bit_nxt  = 3'd7;
        byte_nxt = '0;
        sclk_nxt = 1'b0;
        csn_nxt  = 1'b1;
        if (req) begin
          state_nxt = CS_SETUP;
          csn_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          wr_nxt    = req_write;
          addr_nxt  = req_addr;
          wdata_nxt = i_Wdata;
          last_nxt  = req_n + 4'd1;
          tx_nxt    = req_write ? CMD_WRITE : CMD_READ;
          mosi_nxt  = req_write ? CMD_WRITE[7] : CMD_READ[7];
          src_nxt   = req_src;
        end
      end

      CS_SETUP: begin
        div_nxt = div_cnt + DIV_W'(1);
        if (div_last) begin
          div_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        div_nxt = div_cnt + DIV_W'(1);
        if (div_last) begin
          div_nxt  = '0;
          sclk_nxt = ~sclk;
          // End of the high phase: sample MISO and advance MOSI on the falling edge.
          if (sclk) begin
            rx_nxt = rx_full;
            if (bit_cnt == 3'd0) begin
              if (byte_cnt >= 4'd2 && !is_write) begin
                rvalid_nxt = 1'b1;
                rdata_nxt  = rx_full;
                idx_nxt    = 3'(byte_cnt - 4'd2);
              end
              if (byte_cnt == last_byte) begin
                state_nxt = CS_HOLD;
                mosi_nxt  = 1'b0;
              end else begin
                byte_nxt = byte_cnt + 4'd1;
                bit_nxt  = 3'd7;
                tx_nxt   = next_tx;
                mosi_nxt = next_tx[7];
              end
            end else begin
              bit_nxt  = bit_cnt - 3'd1;
              tx_nxt   = {tx[6:0], 1'b0};
              mosi_nxt = tx[6];
            end
          end
        end
      end

      CS_HOLD: begin
        div_nxt = div_cnt + DIV_W'(1);
        if (div_last) begin
          div_nxt   = '0;
          state_nxt = CS_GAP;
          csn_nxt   = 1'b1;
        end
      end

      CS_GAP: begin
        div_nxt = div_cnt + DIV_W'(1);
        if (div_last) begin
          div_nxt   = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign o_Busy      = busy;
  assign o_Done      = done;
  assign o_Rdata     = rdata;
  assign o_Rvalid    = rvalid;
  assign o_Byte_Idx  = byte_idx;
  assign o_Src       = src;
  assign o_SPI_Clk   = sclk;
  assign o_SPI_CSLow = cs_n;
  assign o_SPI_Mosi  = mosi;

endmodule

`default_nettype wire

// File: tb/tb_accel_spi_controller.sv
// tb_accel_spi_controller: table-driven and randomized frames checked against a byte-level SPI model.
// Rev 1.0
`default_nettype none

module tb_accel_spi_controller;
  localparam int D  = 4;
  localparam int MB = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, write;
  logic [7:0] addr, wdata;
  logic [2:0] len;
  logic       miso;

  logic       busy_a, done_a, rvalid_a, src_a, sclk_a, csn_a, mosi_a;
  logic [7:0] rdata_a;
  logic [2:0] idx_a;

  logic       mon_busy, mon_done, mon_rvalid, mon_src, mon_sclk, mon_csn, mon_mosi;
  logic [7:0] mon_rdata;
  logic [2:0] mon_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

`ifdef ACCEL_SPI_AUTOPOLL_EN
  logic       reset_b, sel;
  logic       busy_b, done_b, rvalid_b, src_b, sclk_b, csn_b, mosi_b;
  logic [7:0] rdata_b;
  logic [2:0] idx_b;

  accel_spi_controller #(.CLK_DIV(D), .MAX_BURST(MB), .POLL_ADDR(8'h0E), .POLL_PERIOD(200000)) dut (
    .clk(clk), .reset(reset), .i_Start(start), .i_Write(write), .i_Addr(addr),
    .i_Wdata(wdata), .i_Len(len), .o_Busy(busy_a), .o_Done(done_a), .o_Rdata(rdata_a),
    .o_Rvalid(rvalid_a), .o_Byte_Idx(idx_a), .o_Src(src_a), .o_SPI_Clk(sclk_a),
    .o_SPI_CSLow(csn_a), .o_SPI_Mosi(mosi_a), .i_SPI_Miso(miso));

  accel_spi_controller #(.CLK_DIV(D), .MAX_BURST(MB), .POLL_ADDR(8'h0E), .POLL_PERIOD(300)) dut_poll (
    .clk(clk), .reset(reset_b), .i_Start(start), .i_Write(write), .i_Addr(addr),
    .i_Wdata(wdata), .i_Len(len), .o_Busy(busy_b), .o_Done(done_b), .o_Rdata(rdata_b),
    .o_Rvalid(rvalid_b), .o_Byte_Idx(idx_b), .o_Src(src_b), .o_SPI_Clk(sclk_b),
    .o_SPI_CSLow(csn_b), .o_SPI_Mosi(mosi_b), .i_SPI_Miso(miso));

  always_comb begin
    if (sel) begin
      {mon_busy, mon_done, mon_rvalid, mon_src} = {busy_b, done_b, rvalid_b, src_b};
      {mon_sclk, mon_csn, mon_mosi, mon_rdata, mon_idx} = {sclk_b, csn_b, mosi_b, rdata_b, idx_b};
    end else begin
      {mon_busy, mon_done, mon_rvalid, mon_src} = {busy_a, done_a, rvalid_a, src_a};
      {mon_sclk, mon_csn, mon_mosi, mon_rdata, mon_idx} = {sclk_a, csn_a, mosi_a, rdata_a, idx_a};
    end
  end
`else
  accel_spi_controller #(.CLK_DIV(D), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .i_Start(start), .i_Write(write), .i_Addr(addr),
    .i_Wdata(wdata), .i_Len(len), .o_Busy(busy_a), .o_Done(done_a), .o_Rdata(rdata_a),
    .o_Rvalid(rvalid_a), .o_Byte_Idx(idx_a), .o_Src(src_a), .o_SPI_Clk(sclk_a),
    .o_SPI_CSLow(csn_a), .o_SPI_Mosi(mosi_a), .i_SPI_Miso(miso));

  assign {mon_busy, mon_done, mon_rvalid, mon_src} = {busy_a, done_a, rvalid_a, src_a};
  assign {mon_sclk, mon_csn, mon_mosi, mon_rdata, mon_idx} = {sclk_a, csn_a, mosi_a, rdata_a, idx_a};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference effective data-byte count straight from the length rule.
  function automatic int eff_len(input bit w, input int l);
    if (w) return 1;
    if (l == 0) return 1;
    if (l > MB) return MB;
    return l;
  endfunction

  // Slave reply stream: filler during cmd/addr, then memory bytes from the addressed location.
  function automatic logic stream_bit(input logic [7:0] a, input int f);
    logic [7:0] b;
    int         k;
    k = f / 8;
    if (k == 0)      b = 8'hA5;
    else if (k == 1) b = 8'h5A;
    else             b = mem[8'(int'(a) + k - 2)];
    return b[7 - (f % 8)];
  endfunction

  task automatic capture(input bit w, input logic [7:0] a, input logic [7:0] wd,
                         input int n, input bit exp_src, input int poke);
    logic [7:0] got   [8];
    logic [7:0] exp_b [8];
    int  rises, falls, cs_cyc, done_cyc, rcnt, nb;
    bit  prev, poked, seen, done_seen;
    nb = 2 + n;
    exp_b[0] = w ? 8'h0A : 8'h0B;
    exp_b[1] = a;
    for (int k = 0; k < 8; k++) begin
      got[k] = 8'h00;
      if (k >= 2) exp_b[k] = w ? wd : 8'h00;
    end
    rises = 0; falls = 0; rcnt = 0; cs_cyc = 0; done_cyc = 0;
    prev = 1'b0; poked = 1'b0; seen = 1'b0; done_seen = 1'b0;
    miso = stream_bit(a, 0);
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (!poked && poke >= 0 && rises == poke) begin
        poked = 1'b1;
        start = 1'b1; write = 1'b1; addr = 8'hFF; wdata = 8'hFF; len = 3'd7;
      end
      if (!seen && !mon_csn) begin
        seen = 1'b1;
        cs_cyc = cyc;
        check("busy_at_cs_fall", mon_busy, 1);
      end
      if (seen && mon_sclk && !prev) begin
        if (rises < 64) got[rises / 8][7 - (rises % 8)] = mon_mosi;
        rises++;
      end
      if (seen && !mon_sclk && prev) begin
        falls++;
        miso = stream_bit(a, falls);
      end
      prev = mon_sclk;
      if (mon_rvalid) begin
        check("rdata", mon_rdata, mem[8'(int'(a) + rcnt)]);
        check("byte_idx", mon_idx, rcnt);
        rcnt++;
      end
      if (mon_done) begin
        done_seen = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!done_seen) begin
      check("frame_timeout", 0, 1);
    end else begin
      check("done_latency", done_cyc - cs_cyc, D * (3 + 16 * nb));
      check("sclk_rises", rises, 8 * nb);
      for (int k = 0; k < nb; k++) check("mosi_byte", got[k], exp_b[k]);
      check("rvalid_count", rcnt, w ? 0 : n);
      check("busy_at_done", mon_busy, 0);
      check("src", mon_src, exp_src);
    end
  endtask

  task automatic run_frame(input bit w, input logic [7:0] a, input logic [7:0] wd,
                           input logic [2:0] l, input int n, input int poke);
    for (int i = 0; i < 3000 && mon_busy; i++) @(negedge clk);
    @(negedge clk);
    start = 1'b1; write = w; addr = a; wdata = wd; len = l;
    @(posedge clk);
    #1 start = 1'b0;
    capture(w, a, wd, n, 1'b0, poke);
  endtask

  typedef struct {
    bit         w;
    logic [7:0] a;
    logic [7:0] wd;
    logic [2:0] l;
    int         n;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int lows, rises;
    bit prev;

    tbl[0] = '{1'b1, 8'h2D, 8'h02, 3'd0, 1};
    tbl[1] = '{1'b0, 8'h00, 8'h00, 3'd1, 1};
    tbl[2] = '{1'b0, 8'h10, 8'h00, 3'd7, 6};
    tbl[3] = '{1'b0, 8'h20, 8'h00, 3'd0, 1};
    tbl[4] = '{1'b0, 8'h0E, 8'h00, 3'd6, 6};
    tbl[5] = '{1'b1, 8'h55, 8'hA5, 3'd7, 1};
    tbl[6] = '{1'b0, 8'hFE, 8'h00, 3'd3, 3};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hAD;

    reset = 1'b1; start = 1'b0; write = 1'b0; addr = 8'h00; wdata = 8'h00; len = 3'd0; miso = 1'b0;
`ifdef ACCEL_SPI_AUTOPOLL_EN
    reset_b = 1'b1; sel = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_cs", mon_csn, 1);
    check("rst_sclk", mon_sclk, 0);
    check("rst_mosi", mon_mosi, 0);
    check("rst_busy", mon_busy, 0);
    check("rst_done", mon_done, 0);
    check("rst_rvalid", mon_rvalid, 0);
    check("rst_rdata", mon_rdata, 0);
    check("rst_idx", mon_idx, 0);
    check("rst_src", mon_src, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].l, tbl[i].n, -1);

    for (int i = 0; i < 10; i++) begin
      bit         w;
      logic [7:0] a, wd;
      logic [2:0] l;
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      wd = 8'($urandom);
      l  = 3'($urandom_range(0, 7));
      run_frame(w, a, wd, l, eff_len(w, int'(l)), -1);
    end

    // Start strobe during the 5th SCLK must be dropped without queueing.
    run_frame(1'b0, 8'h40, 8'h00, 3'd2, 2, 5);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (!mon_csn) lows++;
    end
    check("no_queued_start", lows, 0);

    // Reset in the middle of the address byte.
    @(negedge clk);
    start = 1'b1; write = 1'b0; addr = 8'h33; len = 3'd2;
    @(posedge clk);
    #1 start = 1'b0;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 2000 && rises < 10; i++) begin
      @(negedge clk);
      if (mon_sclk && !prev) rises++;
      prev = mon_sclk;
    end
    check("reached_addr_byte", rises, 10);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cs", mon_csn, 1);
    check("midrst_sclk", mon_sclk, 0);
    check("midrst_busy", mon_busy, 0);
    check("midrst_done", mon_done, 0);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (mon_done || mon_rvalid || !mon_csn) lows++;
    end
    check("midrst_quiet", lows, 0);
    run_frame(1'b0, 8'h33, 8'h00, 3'd2, 2, -1);

    // No autonomous frame on the main instance while idle.
    lows = 0;
    repeat (1200) begin
      @(negedge clk);
      if (!mon_csn) lows++;
    end
    check("idle_no_frame", lows, 0);
    check("idle_src", mon_src, 0);

`ifdef ACCEL_SPI_AUTOPOLL_EN
    sel = 1'b1;
    @(negedge clk);
    reset_b = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    start = 1'b1; write = 1'b0; addr = 8'h30; len = 3'd2;
    @(posedge clk);
    #1 start = 1'b0;
    capture(1'b0, 8'h30, 8'h00, 2, 1'b0, -1);
    capture(1'b0, 8'h0E, 8'h00, MB, 1'b1, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
